// File: rtl/abs_sat_scheduler_pkg.sv
// Shared constants and types for the abs_sat_scheduler slice: FSM encoding,
// default geometry and the clipped-result counter ceiling.
package abs_sat_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ID_W    = 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_OUTPUT  = 2'd2;

  localparam logic [7:0] SAT_CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_COMPUTE = S_COMPUTE,
    ST_OUTPUT  = S_OUTPUT
  } state_e;

endpackage

// File: rtl/abs_sat_scheduler_if.sv
// Requester and result handshake bundle. The master side offers operands and
// consumes results; the scheduler sits on the slave side.
interface abs_sat_scheduler_if
  import abs_sat_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = DEF_ID_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_W-2:0]         res_data;
  logic [ID_W-1:0]           res_id;
  logic                      res_sat;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_sat
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_id, res_sat
  );

endinterface

// File: rtl/abs_sat_scheduler_rr_grant.sv
// Purely combinational round-robin pick: the lowest requesting index at or
// above ptr wins; if none, the lowest requesting index overall wraps around.
module rr_grant #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_valid
);

  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             found_hi;
  logic             found_lo;

  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    // Scan downward so the smallest qualifying index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx   = IDX_W'(i);
        found_lo = 1'b1;
        if (IDX_W'(i) >= ptr) begin
          hi_idx   = IDX_W'(i);
          found_hi = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant     = found_hi ? hi_idx : lo_idx;
    any_valid = found_lo;
  end

endmodule

// File: rtl/abs_saturation.sv
// Combinational magnitude of a signed operand, clipped to DATA_W-1 bits.
// Only the most negative operand overflows; it maps to all-ones with sat set.
module abs_saturation #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] op,
  output logic [DATA_W-2:0] mag,
  output logic              sat
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] neg;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case can leave it unassigned and infer a latch.
    neg = '0;
    mag = '0;
    sat = 1'b0;
    neg = -op;
    sat = (op == MOST_NEG);
    if (sat) begin
      mag = '1;
    end else if (op[DATA_W-1]) begin
      mag = neg[DATA_W-2:0];
    end else begin
      mag = op[DATA_W-2:0];
    end
  end

endmodule

// File: rtl/abs_sat_scheduler.sv
// Round-robin scheduler sharing one abs_saturation unit between NUM_REQ
// requesters; IDLE -> COMPUTE -> OUTPUT, one result in flight at a time.
module abs_sat_scheduler
  import abs_sat_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic                 clk,
  input  logic                 reset,
  abs_sat_scheduler_if.slave   bus,
  output logic [7:0]           sat_count,
  output logic                 busy
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-2:0] res_data_q, res_data_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              res_sat_q, res_sat_d;
  logic [7:0]        sat_count_q, sat_count_d;

  logic [ID_W-1:0]   grant;
  logic              any_valid;
  logic [DATA_W-2:0] abs_mag;
  logic              abs_sat;
  logic [NUM_REQ-1:0] req_ready;
  logic              res_valid;

  rr_grant #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_grant (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  abs_saturation #(
    .DATA_W (DATA_W)
  ) u_abs_saturation (
    .op  (op_q),
    .mag (abs_mag),
    .sat (abs_sat)
  );

  // State register: synchronous active-low reset discards any in-flight work.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    if (!reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      op_q        <= '0;
      id_q        <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      id_q        <= id_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_sat_q   <= res_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    id_d        = id_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_sat_d   = res_sat_q;
    sat_count_d = sat_count_q;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
              op_d = bus.req_data[i*DATA_W +: DATA_W];
            end
          end
          id_d     = grant;
          rr_ptr_d = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          state_d  = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        res_data_d = abs_mag;
        res_sat_d  = abs_sat;
        res_id_d   = id_q;
        state_d    = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
          if (res_sat_q && (sat_count_q != SAT_CNT_MAX)) begin
            sat_count_d = sat_count_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs. req_ready is masked while reset is held so no requester sees an
  // accept strobe that the reset edge is about to discard.
  always_comb begin
    req_ready = '0;
    res_valid = (state_q == ST_OUTPUT);
    busy      = (state_q != ST_IDLE);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = reset && (state_q == ST_IDLE) && any_valid && (grant == ID_W'(i));
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_sat   = res_sat_q;
  assign sat_count     = sat_count_q;

endmodule

// File: tb/tb_abs_sat_scheduler.sv
// Self-checking bench for abs_sat_scheduler: scenario tasks compared against a
// transaction-level model (round-robin pick, clipped magnitude, capped count).
module tb_abs_sat_scheduler;
  import abs_sat_pkg::*;

  localparam int N  = DEF_NUM_REQ;
  localparam int DW = DEF_DATA_W;
  localparam int IW = DEF_ID_W;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sat_count;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int model_ptr    = 0;
  int model_sat    = 0;

  abs_sat_scheduler_if #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) bus ();

  abs_sat_scheduler #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .sat_count (sat_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model.
  function automatic int exp_mag(input logic [7:0] op);
    int v;
    v = $signed(op);
    if (v < 0) v = -v;
    if (v > 127) v = 127;
    return v;
  endfunction

  function automatic logic exp_sat(input logic [7:0] op);
    return ($signed(op) < -127);
  endfunction

  function automatic int exp_grant(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_count(input logic s);
    if (s && model_sat < 255) model_sat++;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req_valid = '1;
    bus.req_data  = 32'($urandom);
    bus.res_ready = 1'b1;
    repeat (3) begin
      step(); settle();
      tests_run++; if (bus.req_ready !== 4'b0) begin tests_failed++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
      tests_run++; if (bus.res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
      tests_run++; if (sat_count !== 8'd0) begin tests_failed++; $display("FAIL reset_sat_count got=%0d exp=0", sat_count); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    end
    step();
    reset = 1'b1;
    bus.req_valid = '0;
    model_ptr = 0;
    model_sat = 0;
  endtask

  task automatic test_round_robin();
    logic [7:0] ops [N];
    int exp_q [$];
    int id_q  [$];
    int grants, results, last, g, e, id;
    ops[0] = 8'd5; ops[1] = 8'hFB; ops[2] = 8'd0; ops[3] = 8'd127;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = ops[i];
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    grants = 0; results = 0; last = -1;
    for (int cyc = 0; cyc < 40 && results < 5; cyc++) begin
      settle();
      if (bus.res_valid === 1'b1) begin
        e = exp_q.pop_front(); id = id_q.pop_front();
        tests_run++; if (bus.res_data !== 7'(e)) begin tests_failed++; $display("FAIL rr_data got=%0d exp=%0d", bus.res_data, e); end
        tests_run++; if (bus.res_id !== 2'(id)) begin tests_failed++; $display("FAIL rr_id got=%0d exp=%0d", bus.res_id, id); end
        results++;
      end
      if (bus.req_ready !== 4'b0 && grants < 5) begin
        g = exp_grant(4'hF, model_ptr);
        tests_run++; if (bus.req_ready !== 4'(1 << g)) begin tests_failed++; $display("FAIL rr_grant got=%b exp=%b", bus.req_ready, 4'(1 << g)); end
        if (last >= 0) begin
          tests_run++; if (cyc - last != 3) begin tests_failed++; $display("FAIL rr_interval got=%0d exp=3", cyc - last); end
        end
        last = cyc;
        exp_q.push_back(exp_mag(ops[g]));
        id_q.push_back(g);
        model_ptr = (g + 1) % N;
        grants++;
      end
      step();
    end
    bus.req_valid = '0;
    tests_run++; if (grants != 5) begin tests_failed++; $display("FAIL rr_grant_count got=%0d exp=5", grants); end
    tests_run++; if (results != 5) begin tests_failed++; $display("FAIL rr_result_count got=%0d exp=5", results); end
  endtask

  task automatic test_single();
    bus.req_data = '0;
    bus.req_data[2*DW +: DW] = 8'hF6;
    bus.req_valid = 4'b0100;
    bus.res_ready = 1'b1;
    settle();
    tests_run++; if (bus.req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_accept got=%b exp=0100", bus.req_ready); end
    model_ptr = (exp_grant(4'b0100, model_ptr) + 1) % N;
    step(); bus.req_valid = '0; settle();
    tests_run++; if (bus.res_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_valid got=%b exp=0", bus.res_valid); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy got=%b exp=1", busy); end
    step(); settle();
    tests_run++; if (bus.res_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid got=%b exp=1", bus.res_valid); end
    tests_run++; if (bus.res_data !== 7'd10) begin tests_failed++; $display("FAIL single_data got=%0d exp=10", bus.res_data); end
    tests_run++; if (bus.res_id !== 2'd2) begin tests_failed++; $display("FAIL single_id got=%0d exp=2", bus.res_id); end
    tests_run++; if (bus.res_sat !== 1'b0) begin tests_failed++; $display("FAIL single_sat got=%b exp=0", bus.res_sat); end
    step(); settle();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle got=%b exp=0", busy); end
    tests_run++; if (sat_count !== 8'(model_sat)) begin tests_failed++; $display("FAIL single_sat_count got=%0d exp=%0d", sat_count, model_sat); end
  endtask

  task automatic test_back_pressure();
    logic [7:0] op1, op2;
    int g;
    op1 = 8'($urandom); op2 = 8'($urandom);
    bus.req_data = '0;
    bus.req_data[1*DW +: DW] = op1;
    bus.req_data[2*DW +: DW] = op2;
    bus.req_valid = 4'b0010;
    bus.res_ready = 1'b0;
    settle();
    tests_run++; if (bus.req_ready !== 4'b0010) begin tests_failed++; $display("FAIL bp_accept got=%b exp=0010", bus.req_ready); end
    model_ptr = 2;
    step(); bus.req_valid = 4'hF; settle();
    tests_run++; if (bus.req_ready !== 4'b0) begin tests_failed++; $display("FAIL bp_compute_ready got=%b exp=0000", bus.req_ready); end
    step(); settle();
    for (int c = 0; c < 6; c++) begin
      tests_run++; if (bus.res_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_hold_valid cycle %0d got=%b exp=1", c, bus.res_valid); end
      tests_run++; if (bus.res_data !== 7'(exp_mag(op1))) begin tests_failed++; $display("FAIL bp_hold_data cycle %0d got=%0d exp=%0d", c, bus.res_data, exp_mag(op1)); end
      tests_run++; if (bus.res_id !== 2'd1) begin tests_failed++; $display("FAIL bp_hold_id cycle %0d got=%0d exp=1", c, bus.res_id); end
      tests_run++; if (bus.res_sat !== exp_sat(op1)) begin tests_failed++; $display("FAIL bp_hold_sat cycle %0d got=%b exp=%b", c, bus.res_sat, exp_sat(op1)); end
      tests_run++; if (bus.req_ready !== 4'b0) begin tests_failed++; $display("FAIL bp_no_accept cycle %0d got=%b exp=0000", c, bus.req_ready); end
      if (c == 5) bus.res_ready = 1'b1;
      step(); settle();
    end
    model_count(exp_sat(op1));
    g = exp_grant(4'hF, model_ptr);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_idle got=%b exp=0", busy); end
    tests_run++; if (bus.req_ready !== 4'(1 << g)) begin tests_failed++; $display("FAIL bp_next_accept got=%b exp=%b", bus.req_ready, 4'(1 << g)); end
    model_ptr = (g + 1) % N;
    step(); bus.req_valid = '0;
    step(); settle();
    tests_run++; if (bus.res_data !== 7'(exp_mag(op2))) begin tests_failed++; $display("FAIL bp_next_data got=%0d exp=%0d", bus.res_data, exp_mag(op2)); end
    tests_run++; if (bus.res_id !== 2'(g)) begin tests_failed++; $display("FAIL bp_next_id got=%0d exp=%0d", bus.res_id, g); end
    step(); settle();
    model_count(exp_sat(op2));
    tests_run++; if (sat_count !== 8'(model_sat)) begin tests_failed++; $display("FAIL bp_sat_count got=%0d exp=%0d", sat_count, model_sat); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 80; it++) begin
      logic [N-1:0] mask;
      logic [7:0]   ops [N];
      logic [N-1:0] exp_rdy;
      logic [7:0]   op;
      int g, stall;
      mask = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        ops[i] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
        bus.req_data[i*DW +: DW] = ops[i];
      end
      stall = $urandom_range(0, 3);
      bus.req_valid = mask;
      bus.res_ready = (stall == 0);
      settle();
      g = exp_grant(mask, model_ptr);
      exp_rdy = (g < 0) ? 4'b0 : 4'(1 << g);
      tests_run++; if (bus.req_ready !== exp_rdy) begin tests_failed++; $display("FAIL rand_grant iter %0d got=%b exp=%b", it, bus.req_ready, exp_rdy); end
      if (g < 0) begin
        step();
      end else begin
        op = ops[g];
        model_ptr = (g + 1) % N;
        step(); bus.req_valid = 4'($urandom); settle();
        tests_run++; if (bus.req_ready !== 4'b0 || bus.res_valid !== 1'b0) begin tests_failed++; $display("FAIL rand_compute iter %0d ready=%b valid=%b exp 0000/0", it, bus.req_ready, bus.res_valid); end
        step(); bus.req_valid = 4'($urandom); settle();
        for (int s = 0; s <= stall; s++) begin
          tests_run++; if (bus.res_valid !== 1'b1) begin tests_failed++; $display("FAIL rand_valid iter %0d got=%b exp=1", it, bus.res_valid); end
          tests_run++; if (bus.res_data !== 7'(exp_mag(op))) begin tests_failed++; $display("FAIL rand_data iter %0d op=%h got=%0d exp=%0d", it, op, bus.res_data, exp_mag(op)); end
          tests_run++; if (bus.res_id !== 2'(g) || bus.res_sat !== exp_sat(op)) begin tests_failed++; $display("FAIL rand_id_sat iter %0d got=%0d/%b exp=%0d/%b", it, bus.res_id, bus.res_sat, g, exp_sat(op)); end
          tests_run++; if (bus.req_ready !== 4'b0) begin tests_failed++; $display("FAIL rand_out_ready iter %0d got=%b exp=0000", it, bus.req_ready); end
          if (s < stall) begin
            step(); bus.req_valid = 4'($urandom); bus.res_ready = (s == stall - 1); settle();
          end
        end
        bus.req_valid = '0;
        step(); settle();
        model_count(exp_sat(op));
        tests_run++; if (sat_count !== 8'(model_sat) || busy !== 1'b0) begin tests_failed++; $display("FAIL rand_after iter %0d count=%0d busy=%b exp=%0d/0", it, sat_count, busy, model_sat); end
      end
    end
  endtask

  task automatic test_saturation();
    bus.req_data = {N{8'h80}};
    bus.res_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, N - 1);
      bus.req_valid = 4'(1 << r);
      settle();
      tests_run++; if (bus.req_ready !== 4'(1 << r)) begin tests_failed++; $display("FAIL sat_accept n=%0d got=%b exp=%b", n, bus.req_ready, 4'(1 << r)); end
      model_ptr = (r + 1) % N;
      step(); bus.req_valid = '0;
      step(); settle();
      tests_run++; if (bus.res_valid !== 1'b1 || bus.res_data !== 7'd127) begin tests_failed++; $display("FAIL sat_data n=%0d valid=%b got=%0d exp=127", n, bus.res_valid, bus.res_data); end
      tests_run++; if (bus.res_sat !== 1'b1) begin tests_failed++; $display("FAIL sat_flag n=%0d got=%b exp=1", n, bus.res_sat); end
      step(); settle();
      model_count(1'b1);
      tests_run++; if (sat_count !== 8'(model_sat)) begin tests_failed++; $display("FAIL sat_count n=%0d got=%0d exp=%0d", n, sat_count, model_sat); end
    end
    tests_run++; if (sat_count !== 8'd255) begin tests_failed++; $display("FAIL sat_count_ceiling got=%0d exp=255", sat_count); end
  endtask

  task automatic test_reset_mid();
    bus.req_data = {N{8'h80}};
    bus.req_valid = 4'b1000;
    bus.res_ready = 1'b1;
    settle();
    tests_run++; if (bus.req_ready !== 4'b1000) begin tests_failed++; $display("FAIL rmid_accept got=%b exp=1000", bus.req_ready); end
    step(); settle();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rmid_compute got=%b exp=1", busy); end
    reset = 1'b0;
    bus.req_valid = 4'hF;
    step(); settle();
    model_ptr = 0;
    model_sat = 0;
    tests_run++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_state valid=%b busy=%b exp 0/0", bus.res_valid, busy); end
    tests_run++; if (bus.res_data !== 7'd0 || bus.res_id !== 2'd0 || bus.res_sat !== 1'b0) begin tests_failed++; $display("FAIL rmid_outputs got=%0d/%0d/%b exp=0/0/0", bus.res_data, bus.res_id, bus.res_sat); end
    tests_run++; if (sat_count !== 8'd0) begin tests_failed++; $display("FAIL rmid_sat_count got=%0d exp=0", sat_count); end
    tests_run++; if (bus.req_ready !== 4'b0) begin tests_failed++; $display("FAIL rmid_ready_in_reset got=%b exp=0000", bus.req_ready); end
    reset = 1'b1;
    settle();
    tests_run++; if (bus.req_ready !== 4'b0001) begin tests_failed++; $display("FAIL rmid_restart got=%b exp=0001", bus.req_ready); end
    model_ptr = 1;
    step(); bus.req_valid = '0;
    step(); settle();
    tests_run++; if (bus.res_id !== 2'd0 || bus.res_data !== 7'd127) begin tests_failed++; $display("FAIL rmid_result got=%0d/%0d exp=0/127", bus.res_id, bus.res_data); end
    step(); settle();
    model_count(1'b1);
    tests_run++; if (sat_count !== 8'(model_sat)) begin tests_failed++; $display("FAIL rmid_count_after got=%0d exp=%0d", sat_count, model_sat); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_back_pressure();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
